// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns, COLS_PER_CYCLE columns per clock, valid/ready on both ports.
// Optional INV_MIX_BYPASS_EN adds in_bypass to pass a state through unchanged.
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
`ifdef INV_MIX_BYPASS_EN
    input  logic         in_bypass,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
            $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Counter step; a 4-column group wraps the 2-bit counter straight back to 0.
    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_nx;
    logic [127:0]   r_work;
    logic [127:0]   w_work_nx;
    logic [127:0]   r_out;
    logic [1:0]     r_col;
    logic           w_last;
`ifdef INV_MIX_BYPASS_EN
    logic           r_bypass;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] s);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = s[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        inv_col[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
        inv_col[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
        inv_col[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
        inv_col[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    endfunction

    assign w_last = (r_col == LAST);

    // Transform only the columns of the current group, in place.
    always_comb begin
        w_work_nx = r_work;
        for (int j = 0; j < 4; j++) begin
            if ((j / COLS_PER_CYCLE) == (int'(r_col) / COLS_PER_CYCLE)) begin
                w_work_nx[127-32*j -: 32] = inv_col(r_work[127-32*j -: 32]);
            end
        end
`ifdef INV_MIX_BYPASS_EN
        if (r_bypass) begin
            w_work_nx = r_work;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nx = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work   <= '0;
            r_out    <= '0;
            r_col    <= '0;
`ifdef INV_MIX_BYPASS_EN
            r_bypass <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_work   <= in_data;
                        r_col    <= '0;
`ifdef INV_MIX_BYPASS_EN
                        r_bypass <= in_bypass;
`endif
                    end
                end
                S_BUSY: begin
                    r_work <= w_work_nx;
                    r_col  <= r_col + STEP;
                    // Result register changes only when a block completes.
                    if (w_last) begin
                        r_out <= w_work_nx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data = r_out;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq: three instances (1, 2, 4 columns per clock)
// checked every cycle against a GF(2^8) reference model with a latency scoreboard.
module tb_inv_mix_columns_seq;

`ifdef INV_MIX_BYPASS_EN
    localparam bit BYP_EN = 1'b1;
`else
    localparam bit BYP_EN = 1'b0;
`endif

    localparam logic [127:0] IN2  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] EXP2 = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] IN3  = 128'h4d7ebdf8_c6c6c6c6_8e4da1bc_00000000;
    localparam logic [127:0] EXP3 = 128'h2d26314c_c6c6c6c6_db135345_00000000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_bypass = 1'b0;
    logic              out_ready = 1'b1;
    logic [127:0]      in_data = '0;
    logic [2:0]        rdy;
    logic [2:0]        vld;
    logic [2:0][127:0] od;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_data(in_data),
`ifdef INV_MIX_BYPASS_EN
        .in_bypass(in_bypass),
`endif
        .out_valid(vld[0]), .out_ready(out_ready), .out_data(od[0]));

    inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_data(in_data),
`ifdef INV_MIX_BYPASS_EN
        .in_bypass(in_bypass),
`endif
        .out_valid(vld[1]), .out_ready(out_ready), .out_data(od[1]));

    inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_data(in_data),
`ifdef INV_MIX_BYPASS_EN
        .in_bypass(in_bypass),
`endif
        .out_valid(vld[2]), .out_ready(out_ready), .out_data(od[2]));

    // Reference GF(2^8) multiply, shift-and-add form.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] invmix(input logic [127:0] s);
        logic [7:0]   coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        logic [127:0] r = '0;
        logic [7:0]   t;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                t = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    t = t ^ gmul(coef[(k - row + 4) % 4], s[127-32*c-8*k -: 8]);
                end
                r[127-32*c-8*row -: 8] = t;
            end
        end
        return r;
    endfunction

    function automatic int ncyc(input int k);
        return 4 >> k;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: accepted block becomes visible exactly ncyc clocks later.
    logic [2:0]   m_idle = 3'b111;
    logic [2:0]   m_valid = 3'b000;
    int           m_left [3];
    logic [127:0] m_next [3];
    logic [127:0] m_out [3] = '{default: '0};

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_idle[k]  = 1'b1;
                m_valid[k] = 1'b0;
                m_out[k]   = '0;
                m_left[k]  = 0;
            end else if (m_valid[k]) begin
                if (out_ready) begin
                    m_valid[k] = 1'b0;
                    m_idle[k]  = 1'b1;
                end
            end else if (m_idle[k]) begin
                if (in_valid) begin
                    m_idle[k] = 1'b0;
                    m_left[k] = ncyc(k);
                    m_next[k] = (BYP_EN && in_bypass) ? in_data : invmix(in_data);
                end
            end else begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    m_valid[k] = 1'b1;
                    m_out[k]   = m_next[k];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            check($sformatf("in_ready[%0d]", k), 128'(rdy[k]), 128'(m_idle[k]));
            check($sformatf("out_valid[%0d]", k), 128'(vld[k]), 128'(m_valid[k]));
            check($sformatf("out_data[%0d]", k), od[k], m_out[k]);
        end
    end

    task automatic send(input logic [127:0] d, input logic b);
        int n = 0;
        while (rdy != 3'b111 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (rdy != 3'b111) begin
            check("send_wait_ready", 128'(rdy), 128'(3'b111));
        end
        in_data   = d;
        in_bypass = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_bypass = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        check("model_case2", invmix(IN2), EXP2);
        check("model_case3", invmix(IN3), EXP3);
        check("model_gmul", 128'(gmul(8'h57, 8'h13)), 128'(8'hfe));

        idle_cycles(3);
        check("reset_ready", 128'(rdy), 128'(3'b111));
        check("reset_valid", 128'(vld), 128'(3'b000));
        rst_n = 1'b1;
        idle_cycles(2);

        // FIPS-197 columns and parameter sweep
        send(IN2, 1'b0);
        idle_cycles(6);
        for (int k = 0; k < 3; k++) check($sformatf("case2_lit[%0d]", k), od[k], EXP2);

        // Round trip of MixColumns examples
        send(IN3, 1'b0);
        idle_cycles(6);
        for (int k = 0; k < 3; k++) check($sformatf("case3_lit[%0d]", k), od[k], EXP3);

        // Backpressure in DONE; a held in_valid must not be captured
        out_ready = 1'b0;
        send(IN2, 1'b0);
        idle_cycles(5);
        in_data  = IN3;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            idle_cycles(1);
            check("bp_hold_data", od[0], EXP2);
            check("bp_ready_low", 128'(rdy), 128'(3'b000));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle_cycles(3);
        check("bp_back_idle", 128'(rdy), 128'(3'b111));
        check("bp_keep_data", od[2], EXP2);

        // Reset in the middle of a transform
        send(IN3, 1'b0);
        idle_cycles(1);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 128'(rdy), 128'(3'b111));
        check("midrst_valid", 128'(vld), 128'(3'b000));
        check("midrst_data0", od[0], 128'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(8);
        check("postrst_novalid", 128'(vld), 128'(3'b000));
        check("postrst_data", od[1], 128'h0);

`ifdef INV_MIX_BYPASS_EN
        send(IN2, 1'b1);
        idle_cycles(6);
        for (int k = 0; k < 3; k++) check($sformatf("bypass_lit[%0d]", k), od[k], IN2);
        send(IN3, 1'b0);
        send(IN2, 1'b1);
        idle_cycles(6);
        check("b2b_bypass", od[0], IN2);
`endif

        send(IN2, 1'b0);
        send(IN3, 1'b0);
        idle_cycles(6);
        check("b2b_last", od[0], EXP3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
